// File: rtl/memory_arbiter.sv
// Two-port block-memory arbiter: instruction-cache reads and data-cache
// reads/write-backs share one unified memory. Ties alternate between ports,
// every grant latches its request and holds it stable until completion or
// timeout, and a one-cycle RELEASE hands the result back to the requester.
//
// Handshake: a cache holds its request high while its BUSYWAIT is high; BUSYWAIT
// drops for exactly the RELEASE cycle of its own transaction, and the cache must
// drop (or renew) its request by the following edge. Memory completes a
// transfer by driving MEM_BUSYWAIT low from the second grant cycle onward.
module memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         I_READ,
    input  logic [5:0]   I_ADDRESS,
    output logic [127:0] I_READDATA,
    output logic         I_BUSYWAIT,
    input  logic         D_READ,
    input  logic         D_WRITE,
    input  logic [5:0]   D_ADDRESS,
    input  logic [127:0] D_WRITEDATA,
    output logic [127:0] D_READDATA,
    output logic         D_BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [6:0]   MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT,
    output logic         TIMEOUT_ERR,
    output logic [1:0]   DEBUG_STATE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Counter holds (grant cycle number - 1), so it only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        next_state;
    logic          last_grant_d;  // 1: data port won the most recent grant
    logic [CW-1:0] cnt;
    logic          done_i;
    logic          done_d;

    logic d_req;
    logic pick_i;
    logic pick_d;
    logic in_grant;
    logic complete;
    logic expire;

    // Arbitration decision and grant termination conditions.
    always_comb begin
        d_req    = D_READ | D_WRITE;
        pick_i   = I_READ && (!d_req || last_grant_d);
        pick_d   = d_req && (!I_READ || !last_grant_d);
        in_grant = (state == GRANT_I) || (state == GRANT_D);
        // MEM_BUSYWAIT low in the first grant cycle (cnt == 0) is stale and ignored.
        complete = in_grant && (cnt != '0) && !MEM_BUSYWAIT;
        expire   = in_grant && !complete && (cnt == CNT_LAST);
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_i)      next_state = GRANT_I;
                else if (pick_d) next_state = GRANT_D;
            end
            GRANT_I, GRANT_D: begin
                if (complete || expire) next_state = RELEASE;
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    // Grant latching, memory strobes, read-data capture, timeout tracking.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
            TIMEOUT_ERR   <= 1'b0;
            cnt           <= '0;
            last_grant_d  <= 1'b1;
            done_i        <= 1'b0;
            done_d        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        last_grant_d <= 1'b0;
                        MEM_ADDRESS  <= {1'b0, I_ADDRESS};
                        MEM_READ     <= 1'b1;
                        MEM_WRITE    <= 1'b0;
                        cnt          <= '0;
                    end else if (pick_d) begin
                        last_grant_d <= 1'b1;
                        MEM_ADDRESS  <= {1'b1, D_ADDRESS};
                        // A simultaneous read and write-back is served as the write.
                        MEM_READ     <= !D_WRITE;
                        MEM_WRITE    <= D_WRITE;
                        if (D_WRITE) MEM_WRITEDATA <= D_WRITEDATA;
                        cnt          <= '0;
                    end
                end
                GRANT_I, GRANT_D: begin
                    if (complete || expire) begin
                        MEM_READ  <= 1'b0;
                        MEM_WRITE <= 1'b0;
                        done_i    <= (state == GRANT_I);
                        done_d    <= (state == GRANT_D);
                        if (expire) TIMEOUT_ERR <= 1'b1;
                        if (complete && MEM_READ) begin
                            if (state == GRANT_I) I_READDATA <= MEM_READDATA;
                            else                  D_READDATA <= MEM_READDATA;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    done_i <= 1'b0;
                    done_d <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign I_BUSYWAIT  = I_READ && !((state == RELEASE) && done_i);
    assign D_BUSYWAIT  = d_req && !((state == RELEASE) && done_d);
    assign DEBUG_STATE = state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a short timeout so expiry is quick.
module tb_memory_arbiter;

    localparam logic [1:0] S_IDLE = 2'd0, S_GI = 2'd1, S_GD = 2'd2, S_REL = 2'd3;
    localparam logic [127:0] PAT_A5   = {16{8'hA5}};
    localparam logic [127:0] PAT_1234 = {8{16'h1234}};
    localparam logic [127:0] PAT_W2   = {4{32'h5A5A_0F0F}};

    logic         CLK = 1'b0;
    logic         RESET;
    logic         I_READ;
    logic [5:0]   I_ADDRESS;
    logic [127:0] I_READDATA;
    logic         I_BUSYWAIT;
    logic         D_READ;
    logic         D_WRITE;
    logic [5:0]   D_ADDRESS;
    logic [127:0] D_WRITEDATA;
    logic [127:0] D_READDATA;
    logic         D_BUSYWAIT;
    logic         MEM_READ;
    logic         MEM_WRITE;
    logic [6:0]   MEM_ADDRESS;
    logic [127:0] MEM_WRITEDATA;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic         TIMEOUT_ERR;
    logic [1:0]   DEBUG_STATE;

    int n_checks = 0;
    int n_fail   = 0;

    memory_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
        .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
        .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .TIMEOUT_ERR(TIMEOUT_ERR), .DEBUG_STATE(DEBUG_STATE)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle 1 ns past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] target, input string tag);
        int n = 0;
        while (DEBUG_STATE !== target && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, DEBUG_STATE, target);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        I_READ = 1'b0; I_ADDRESS = '0;
        D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = '0; D_WRITEDATA = '0;
        MEM_READDATA = '0; MEM_BUSYWAIT = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    initial begin
        do_reset();
        check_eq("rst_state", DEBUG_STATE, S_IDLE);
        check_eq("rst_mem_read", MEM_READ, 1'b0);
        check_eq("rst_mem_write", MEM_WRITE, 1'b0);
        check_eq("rst_mem_addr", MEM_ADDRESS, 7'h00);
        check_eq("rst_mem_wdata", MEM_WRITEDATA, 128'h0);
        check_eq("rst_i_rdata", I_READDATA, 128'h0);
        check_eq("rst_d_rdata", D_READDATA, 128'h0);
        check_eq("rst_timeout", TIMEOUT_ERR, 1'b0);

        // Instruction read, memory busy for 4 grant cycles.
        I_READ = 1'b1; I_ADDRESS = 6'h05; MEM_BUSYWAIT = 1'b1;
        tick();
        check_eq("i_grant_state", DEBUG_STATE, S_GI);
        check_eq("i_mem_read", MEM_READ, 1'b1);
        check_eq("i_mem_write", MEM_WRITE, 1'b0);
        check_eq("i_mem_addr", MEM_ADDRESS, 7'h05);
        check_eq("i_busywait", I_BUSYWAIT, 1'b1);
        I_ADDRESS = 6'h2A;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("i_hold_state", DEBUG_STATE, S_GI);
            check_eq("i_hold_read", MEM_READ, 1'b1);
            check_eq("i_hold_addr", MEM_ADDRESS, 7'h05);
        end
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = PAT_A5;
        tick();
        check_eq("i_rel_state", DEBUG_STATE, S_REL);
        check_eq("i_rel_read", MEM_READ, 1'b0);
        check_eq("i_rel_rdata", I_READDATA, PAT_A5);
        check_eq("i_rel_drdata", D_READDATA, 128'h0);
        check_eq("i_rel_busywait", I_BUSYWAIT, 1'b0);
        I_READ = 1'b0; MEM_BUSYWAIT = 1'b1; MEM_READDATA = '0;
        tick();
        check_eq("i_idle_state", DEBUG_STATE, S_IDLE);
        check_eq("i_idle_rdata", I_READDATA, PAT_A5);

        // Data write-back at minimum latency; early MEM_BUSYWAIT low must be ignored,
        // and dropping the request mid-grant must not abort it.
        D_WRITE = 1'b1; D_ADDRESS = 6'h3F; D_WRITEDATA = PAT_1234;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 128'hDEAD;
        tick();
        check_eq("dw_grant_state", DEBUG_STATE, S_GD);
        check_eq("dw_mem_write", MEM_WRITE, 1'b1);
        check_eq("dw_mem_read", MEM_READ, 1'b0);
        check_eq("dw_mem_addr", MEM_ADDRESS, 7'h7F);
        check_eq("dw_mem_wdata", MEM_WRITEDATA, PAT_1234);
        D_WRITE = 1'b0; D_WRITEDATA = ~PAT_1234;
        tick();
        check_eq("dw_first_ignored", DEBUG_STATE, S_GD);
        check_eq("dw_hold_write", MEM_WRITE, 1'b1);
        check_eq("dw_hold_wdata", MEM_WRITEDATA, PAT_1234);
        tick();
        check_eq("dw_rel_state", DEBUG_STATE, S_REL);
        check_eq("dw_rel_write", MEM_WRITE, 1'b0);
        check_eq("dw_rel_read", MEM_READ, 1'b0);
        check_eq("dw_i_rdata_kept", I_READDATA, PAT_A5);
        tick();
        check_eq("dw_idle_state", DEBUG_STATE, S_IDLE);

        // Tie arbitration with both requests held: I, D, I, D.
        do_reset();
        I_ADDRESS = 6'h11; D_ADDRESS = 6'h22; I_READ = 1'b1; D_READ = 1'b1;
        MEM_BUSYWAIT = 1'b0;
        for (int k = 0; k < 4; k++) begin
            logic          exp_d;
            logic [127:0]  rd;
            exp_d = k[0];
            rd = {96'h0, 32'hC0DE_0000 + 32'(k)};
            MEM_READDATA = rd;
            wait_state(exp_d ? S_GD : S_GI, "arb_grant");
            check_eq("arb_addr", MEM_ADDRESS, exp_d ? 7'h62 : 7'h11);
            check_eq("arb_read", MEM_READ, 1'b1);
            wait_state(S_REL, "arb_release");
            if (exp_d) begin
                check_eq("arb_d_rdata", D_READDATA, rd);
                check_eq("arb_d_bw", D_BUSYWAIT, 1'b0);
                check_eq("arb_i_bw", I_BUSYWAIT, 1'b1);
            end else begin
                check_eq("arb_i_rdata", I_READDATA, rd);
                check_eq("arb_i_bw", I_BUSYWAIT, 1'b0);
                check_eq("arb_d_bw", D_BUSYWAIT, 1'b1);
            end
            tick();
        end
        I_READ = 1'b0; D_READ = 1'b0;
        tick();
        tick();
        check_eq("arb_idle", DEBUG_STATE, S_IDLE);

        // Read and write together: served as a write.
        D_READ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 6'h01; D_WRITEDATA = PAT_W2;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 128'hBEEF;
        tick();
        check_eq("rw_write", MEM_WRITE, 1'b1);
        check_eq("rw_read", MEM_READ, 1'b0);
        check_eq("rw_addr", MEM_ADDRESS, 7'h41);
        check_eq("rw_wdata", MEM_WRITEDATA, PAT_W2);
        tick();
        check_eq("rw_read_c2", MEM_READ, 1'b0);
        tick();
        check_eq("rw_rel_state", DEBUG_STATE, S_REL);
        check_eq("rw_rel_read", MEM_READ, 1'b0);
        D_READ = 1'b0; D_WRITE = 1'b0;
        tick();

        // Timeout: memory never completes.
        I_READ = 1'b1; I_ADDRESS = 6'h03; MEM_BUSYWAIT = 1'b1; MEM_READDATA = 128'hBAD;
        tick();
        check_eq("to_grant", DEBUG_STATE, S_GI);
        repeat (7) tick();
        check_eq("to_cycle8_state", DEBUG_STATE, S_GI);
        check_eq("to_cycle8_read", MEM_READ, 1'b1);
        check_eq("to_cycle8_err", TIMEOUT_ERR, 1'b0);
        tick();
        check_eq("to_rel_state", DEBUG_STATE, S_REL);
        check_eq("to_rel_read", MEM_READ, 1'b0);
        check_eq("to_err", TIMEOUT_ERR, 1'b1);
        check_eq("to_i_bw", I_BUSYWAIT, 1'b0);
        check_eq("to_rdata_kept", I_READDATA, {96'h0, 32'hC0DE_0002});
        I_READ = 1'b0;
        tick();
        check_eq("to_idle", DEBUG_STATE, S_IDLE);
        check_eq("to_err_sticky", TIMEOUT_ERR, 1'b1);
        D_READ = 1'b1; D_ADDRESS = 6'h07; MEM_BUSYWAIT = 1'b0; MEM_READDATA = 128'h77;
        wait_state(S_REL, "to_next_release");
        check_eq("to_next_rdata", D_READDATA, 128'h77);
        check_eq("to_err_still", TIMEOUT_ERR, 1'b1);
        D_READ = 1'b0;
        tick();

        // Reset in the middle of a data grant.
        D_READ = 1'b1; D_ADDRESS = 6'h05; MEM_BUSYWAIT = 1'b1; MEM_READDATA = 128'h99;
        tick();
        check_eq("rg_grant", DEBUG_STATE, S_GD);
        tick();
        RESET = 1'b1; D_READ = 1'b0; MEM_BUSYWAIT = 1'b0;
        tick();
        check_eq("rg_state", DEBUG_STATE, S_IDLE);
        check_eq("rg_read", MEM_READ, 1'b0);
        check_eq("rg_write", MEM_WRITE, 1'b0);
        check_eq("rg_addr", MEM_ADDRESS, 7'h00);
        check_eq("rg_drdata", D_READDATA, 128'h0);
        check_eq("rg_err_cleared", TIMEOUT_ERR, 1'b0);
        check_eq("rg_d_bw", D_BUSYWAIT, 1'b0);
        RESET = 1'b0;
        tick();
        check_eq("rg_no_release", DEBUG_STATE, S_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: max cycles one grant may wait for memory completion.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset; sampled on rising CLK edge.
REQ-004 I_READ  in  1  instruction-cache block read request; held until I_BUSYWAIT low.
REQ-005 I_ADDRESS  in  6  instruction block address.
REQ-006 I_READDATA  out  128  block returned to instruction cache.
REQ-007 I_BUSYWAIT  out  1  instruction request pending.
REQ-008 D_READ  in  1  data-cache block read request.
REQ-009 D_WRITE  in  1  data-cache block write-back request.
REQ-010 D_ADDRESS  in  6  data block address.
REQ-011 D_WRITEDATA  in  128  write-back block.
REQ-012 D_READDATA  out  128  block returned to data cache.
REQ-013 D_BUSYWAIT  out  1  data request pending.
REQ-014 MEM_READ  out  1  unified memory read strobe.
REQ-015 MEM_WRITE  out  1  unified memory write strobe.
REQ-016 MEM_ADDRESS  out  7  unified block address; bit 6 = region (0 instruction, 1 data).
REQ-017 MEM_WRITEDATA  out  128  block to memory.
REQ-018 MEM_READDATA  in  128  block from memory.
REQ-019 MEM_BUSYWAIT  in  1  memory busy; low = transaction complete.
REQ-020 TIMEOUT_ERR  out  1  sticky timeout flag.

Function
REQ-021 States SHALL be IDLE, GRANT_I, GRANT_D, RELEASE; registered state.
REQ-022 IDLE: only I_READ -> GRANT_I; only D request -> GRANT_D; both -> grant the requester not in last_grant register; none -> stay.
REQ-023 last_grant SHALL update to the granted requester on each IDLE->GRANT transition.
REQ-024 D_READ and D_WRITE both high SHALL be treated as a write.
REQ-025 On grant entry, arbiter SHALL register MEM_ADDRESS = {region, 6-bit address}, MEM_WRITEDATA = D_WRITEDATA (data write only), and assert exactly one of MEM_READ/MEM_WRITE; MEM_READ and MEM_WRITE never high together.
REQ-026 Address/data/direction SHALL be latched at grant and held stable for the whole grant regardless of input changes.
REQ-027 Completion: in GRANT_x, from the second grant cycle onward, MEM_BUSYWAIT sampled low SHALL complete the transaction; MEM_BUSYWAIT low in the first grant cycle is ignored.
REQ-028 On completion, same edge: strobes low, read data latched into I_READDATA or D_READDATA (other output unchanged), state -> RELEASE with done flag for that requester.
REQ-029 I_BUSYWAIT SHALL equal I_READ AND NOT (RELEASE with I done); D_BUSYWAIT SHALL equal (D_READ OR D_WRITE) AND NOT (RELEASE with D done); both combinational.
REQ-030 RELEASE SHALL last exactly one cycle then go to IDLE; new requests are not granted from RELEASE.
REQ-031 Minimum per-transaction latency: request visible in cycle 0, grant cycle 1, completion edge no earlier than end of cycle 2, RELEASE cycle 3.
REQ-032 A grant cycle counter SHALL reset on grant entry; if it reaches TIMEOUT_CYCLES without completion: strobes low, TIMEOUT_ERR set, requester receives done in RELEASE with read data unchanged, state -> RELEASE.
REQ-033 TIMEOUT_ERR SHALL remain high until RESET.
REQ-034 A requester dropping its request mid-grant SHALL not abort the memory transaction; it completes normally.

Reset
REQ-035 RESET high at a rising edge SHALL, in that edge, force state IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, I_READDATA=0, D_READDATA=0, TIMEOUT_ERR=0, counter=0, last_grant=D (instruction wins first tie).
REQ-036 RESET mid-grant SHALL abandon the transaction with no data latched and no done pulse.

Verification
REQ-037 I_READ=1, I_ADDRESS=6'h05, memory busy 4 cycles, data 128'hA5.. -> MEM_READ=1, MEM_ADDRESS=7'h05, I_READDATA=128'hA5.., I_BUSYWAIT low one cycle in RELEASE.
REQ-038 D_WRITE=1, D_ADDRESS=6'h3F, D_WRITEDATA=128'h1234.. -> MEM_WRITE=1, MEM_ADDRESS=7'h7F, MEM_WRITEDATA matches, MEM_READ stays 0.
REQ-039 I_READ and D_READ raised same cycle after reset, held -> I served first, then D; repeat tie -> D after I alternation continues.
REQ-040 D_READ and D_WRITE both high -> write performed, MEM_READ never asserted.
REQ-041 TIMEOUT_CYCLES=8, MEM_BUSYWAIT stuck high -> strobes drop after 8 grant cycles, TIMEOUT_ERR=1, requester released, flag persists until RESET.
REQ-042 RESET asserted during GRANT_D -> next cycle IDLE, all strobes 0, D_READDATA=0, no RELEASE.
